// File: rtl/ntt_butterfly_unit.sv
// Pipelined radix-2 modular butterfly (CT forward / GS inverse per beat) with a writable twiddle table.
// Optional feature macro: BUTTERFLY_SCALE_EN (GS outputs multiplied by 2^-1 mod Q).
// Handshake: in_valid qualifies x_in/y_in/mode for one beat, with no backpressure; out_valid
// marks exactly one result per accepted beat, MULT_LAT+2 cycles later, and outputs hold otherwise.
module ntt_butterfly_unit #(
  parameter int unsigned       WIDTH       = 28,
  parameter logic [WIDTH-1:0]  Q           = WIDTH'(268369921),
  parameter int unsigned       MULT_LAT    = 6,
  parameter int unsigned       NUM_TW      = 4,
  parameter int unsigned       START_DELAY = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        restart,
  input  logic                        in_valid,
  input  logic                        mode,
  input  logic [WIDTH-1:0]            x_in,
  input  logic [WIDTH-1:0]            y_in,
  input  logic                        tw_we,
  input  logic [$clog2(NUM_TW)-1:0]   tw_waddr,
  input  logic [WIDTH-1:0]            tw_wdata,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            x_out,
  output logic [WIDTH-1:0]            y_out
);

  localparam int AW = $clog2(NUM_TW);
  localparam int CW = $clog2(START_DELAY + 2);
  localparam int PW = 2 * WIDTH;
  localparam int BW = 3 * WIDTH + 2;
  localparam logic [PW:0]      MU  = ((PW+1)'(1) << PW) / (PW+1)'(Q);
  localparam logic [WIDTH+1:0] Q_X = {2'b00, Q};
  localparam logic [WIDTH+1:0] Q2X = {1'b0, Q, 1'b0};

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, Q};
    return WIDTH'(d);
  endfunction

`ifdef BUTTERFLY_SCALE_EN
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] t;
    t = v[0] ? ({1'b0, v} + {1'b0, Q}) : {1'b0, v};
    return WIDTH'(t >> 1);
  endfunction
`endif

  // Beat counter / twiddle index: idx_use is the index for a beat accepted this cycle.
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d, idx_use;
  logic [WIDTH-1:0] tw_q [NUM_TW];
  logic [WIDTH-1:0] w_use;

  always_comb begin
    idx_use = restart ? '0 : idx_q;
    cnt_d   = restart ? '0 : cnt_q;
    idx_d   = idx_use;
    if (in_valid) begin
      if (cnt_d < CW'(START_DELAY)) cnt_d = cnt_d + CW'(1);
      else                          idx_d = idx_use + AW'(1);
    end
  end

  assign w_use = tw_q[idx_use];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < NUM_TW; i++) tw_q[i] <= WIDTH'(1);
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (tw_we) tw_q[tw_waddr] <= tw_wdata;
    end
  end

  // Stage A: both modes register here so the single multiplier sees one beat per cycle
  // even in mixed CT/GS streams. GS pre-computes x+y / x-y; CT just forwards x and y.
  logic             a_valid_q, a_mode_q;
  logic [WIDTH-1:0] a_side_q, a_mul_q, a_w_q;

  always_ff @(posedge clk) begin
    if (rst) a_valid_q <= 1'b0;
    else     a_valid_q <= in_valid;
    if (in_valid) begin
      a_mode_q <= mode;
      a_side_q <= mode ? mod_add(x_in, y_in) : x_in;
      a_mul_q  <= mode ? mod_sub(x_in, y_in) : y_in;
      a_w_q    <= w_use;
    end
  end

  // Multiplier: product register, Barrett reduction, then MULT_LAT-1 result registers.
  logic [PW-1:0]       p_q;
  logic [MULT_LAT-1:0] m_valid_q, m_mode_q;
  logic [WIDTH-1:0]    m_side_q [MULT_LAT];
  logic [BW-1:0]       q3;
  logic [WIDTH+1:0]    r0;
  logic [WIDTH-1:0]    red, m_res;

  always_ff @(posedge clk) begin
    if (rst) m_valid_q <= '0;
    else begin
      m_valid_q[0] <= a_valid_q;
      for (int i = 1; i < MULT_LAT; i++) m_valid_q[i] <= m_valid_q[i-1];
    end
    p_q         <= PW'(a_mul_q) * PW'(a_w_q);
    m_mode_q[0] <= a_mode_q;
    m_side_q[0] <= a_side_q;
    for (int i = 1; i < MULT_LAT; i++) begin
      m_mode_q[i] <= m_mode_q[i-1];
      m_side_q[i] <= m_side_q[i-1];
    end
  end

  // Barrett estimate leaves the remainder in [0, 3Q); two conditional subtractions finish it.
  always_comb begin
    q3  = BW'((BW'(p_q >> (WIDTH-1)) * BW'(MU)) >> (WIDTH+1));
    r0  = (WIDTH+2)'(BW'(p_q) - q3 * BW'(Q));
    red = WIDTH'(r0);
    if      (r0 >= Q2X) red = WIDTH'(r0 - Q2X);
    else if (r0 >= Q_X) red = WIDTH'(r0 - Q_X);
  end

  generate
    if (MULT_LAT > 1) begin : g_tail
      logic [WIDTH-1:0] r_q [MULT_LAT-1];
      always_ff @(posedge clk) begin
        r_q[0] <= red;
        for (int i = 1; i < MULT_LAT-1; i++) r_q[i] <= r_q[i-1];
      end
      assign m_res = r_q[MULT_LAT-2];
    end else begin : g_notail
      assign m_res = red;
    end
  endgenerate

  // Final combine: CT does the add/sub against w*y; GS passes (x+y) and (x-y)*w through.
  logic [WIDTH-1:0] fx, fy;

  always_comb begin
    fx = m_side_q[MULT_LAT-1];
    fy = m_res;
    if (!m_mode_q[MULT_LAT-1]) begin
      fx = mod_add(m_side_q[MULT_LAT-1], m_res);
      fy = mod_sub(m_side_q[MULT_LAT-1], m_res);
    end
`ifdef BUTTERFLY_SCALE_EN
    else begin
      fx = mod_half(m_side_q[MULT_LAT-1]);
      fy = mod_half(m_res);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      out_valid <= m_valid_q[MULT_LAT-1];
      if (m_valid_q[MULT_LAT-1]) begin
        x_out <= fx;
        y_out <= fy;
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// Bench for ntt_butterfly_unit: directed and random beats against a mod-Q reference model,
// with a scoreboard queue carrying expected results and their expected output cycle.
module tb_ntt_butterfly_unit;

  localparam int W   = 28;
  localparam logic [W-1:0] QV = 28'd268369921;
  localparam int ML  = 6;
  localparam int NT  = 4;
  localparam int SD  = 2;
  localparam int AW  = 2;
  localparam int LAT = ML + 2;

  logic clk = 1'b0;
  logic rst, restart, in_valid, mode, tw_we, out_valid;
  logic [W-1:0] x_in, y_in, tw_wdata, x_out, y_out;
  logic [AW-1:0] tw_waddr;

  ntt_butterfly_unit #(
    .WIDTH(W), .Q(QV), .MULT_LAT(ML), .NUM_TW(NT), .START_DELAY(SD)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .mode(mode),
    .x_in(x_in), .y_in(y_in), .tw_we(tw_we), .tw_waddr(tw_waddr), .tw_wdata(tw_wdata),
    .out_valid(out_valid), .x_out(x_out), .y_out(y_out)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and model state
  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  int             errors = 0;
  int             checks = 0;
  bit             mon_en = 1'b0;
  logic [W-1:0]   last_x = '0, last_y = '0;
  logic [W-1:0]   m_tw [NT];
  int             m_beats = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned half(input longint unsigned v);
    return (v % 2 == 0) ? v / 2 : (v + QV) / 2;
  endfunction

  function automatic logic [2*W-1:0] model(input bit m, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic [W-1:0] w);
    longint unsigned q, xx, yy, ww, t, rx, ry;
    q = QV; xx = x; yy = y; ww = w;
    if (!m) begin
      t  = (ww * yy) % q;
      rx = (xx + t) % q;
      ry = (xx + q - t) % q;
    end else begin
      rx = (xx + yy) % q;
      ry = (((xx + q - yy) % q) * ww) % q;
`ifdef BUTTERFLY_SCALE_EN
      rx = half(rx);
      ry = half(ry);
`endif
    end
    return {W'(rx), W'(ry)};
  endfunction

  // Monitor: every out_valid pops one expectation; idle cycles must hold the last result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out_valid obs=1 exp=0 x_out=%0d", x_out);
        end
        if (exp_q.size() != 0) begin
          logic [2*W-1:0] e;
          int c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("x_out", x_out, e[2*W-1:W]);
          check("y_out", y_out, e[W-1:0]);
          check_int("latency_cycle", cyc, c);
          last_x = e[2*W-1:W];
          last_y = e[W-1:0];
        end
      end else begin
        check("hold_x", x_out, last_x);
        check("hold_y", y_out, last_y);
      end
    end
  end

  // Driver: one cycle of stimulus; the model consumes the beat before the edge.
  task automatic step(input bit v, input bit m, input logic [W-1:0] x, input logic [W-1:0] y,
                      input bit rs, input bit we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input bit use_k, input logic [W-1:0] kx, input logic [W-1:0] ky,
                      input bit rr);
    int idx;
    logic [2*W-1:0] e;
    in_valid = v; mode = m; x_in = x; y_in = y; restart = rs;
    tw_we = we; tw_waddr = wa; tw_wdata = wd; rst = rr;
    if (rs) m_beats = 0;
    if (v && !rr) begin
      idx = (m_beats <= SD) ? 0 : (m_beats - SD) % NT;
      e = use_k ? {kx, ky} : model(m, x, y, m_tw[idx]);
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + LAT);
      m_beats++;
    end
    @(posedge clk);
    if (rr) begin
      exp_q.delete();
      exp_cyc_q.delete();
      for (int i = 0; i < NT; i++) m_tw[i] = W'(1);
      m_beats = 0;
      last_x = '0;
      last_y = '0;
    end else if (we) begin
      m_tw[wa] = wd;
    end
    @(negedge clk);
    in_valid = 1'b0; restart = 1'b0; tw_we = 1'b0; rst = 1'b0;
  endtask

  task automatic beat_k(input bit m, input logic [W-1:0] x, input logic [W-1:0] y, input bit rs,
                        input logic [W-1:0] kx, input logic [W-1:0] ky);
    step(1'b1, m, x, y, rs, 1'b0, '0, '0, 1'b1, kx, ky, 1'b0);
  endtask

  task automatic beat(input bit m, input logic [W-1:0] x, input logic [W-1:0] y, input bit rs);
    step(1'b1, m, x, y, rs, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic tw_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, a, d, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int kx4 [8];
    int kx5 [9];
    bit rv, rm, rrs, rwe;
    logic [W-1:0] rx, ry, rd;
    logic [AW-1:0] ra;
    kx4 = '{1, 1, 1, 2, 3, 4, 1, 2};
    kx5 = '{1, 1, 1, 2, 3, 1, 1, 1, 2};
    for (int i = 0; i < NT; i++) m_tw[i] = W'(1);
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; tw_we = 1'b0; tw_waddr = '0; tw_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", {27'd0, out_valid}, '0);
    check("reset_x_out", x_out, '0);
    check("reset_y_out", y_out, '0);
    mon_en = 1'b1;

    // Basic CT and modular wrap cases
    beat_k(1'b0, 5, 3, 1'b0, 8, 2);
    idle(LAT + 2);
    beat_k(1'b0, 1, 3, 1'b0, 4, 28'd268369919);
    beat_k(1'b0, QV - 1, 1, 1'b0, 0, 28'd268369919);
    idle(3);

    // 2^28 mod Q reduction through the multiplier
    tw_wr(0, 65536);
    beat_k(1'b0, 0, 4096, 1'b1, 65535, 28'd268304386);
    idle(2);

    // Twiddle index stepping, bubble, restart with a beat
    for (int i = 0; i < NT; i++) tw_wr(AW'(i), W'(i + 1));
    for (int i = 0; i < 8; i++) begin
      beat_k(1'b0, 0, 1, (i == 0), W'(kx4[i]), QV - W'(kx4[i]));
      if (i == 3) idle(1);
    end
    for (int i = 0; i < 9; i++)
      beat_k(1'b0, 0, 1, (i == 0 || i == 5), W'(kx5[i]), QV - W'(kx5[i]));

    // Same-cycle write and read of tw[0]: old value, then new value
    step(1'b1, 1'b0, 0, 1, 1'b1, 1'b1, 0, 9, 1'b1, 1, QV - 1, 1'b0);
    beat_k(1'b0, 0, 1, 1'b0, 9, QV - 9);
    tw_wr(0, 1);

    // GS beats
`ifdef BUTTERFLY_SCALE_EN
    beat_k(1'b1, 5, 3, 1'b1, 4, 1);
    beat_k(1'b1, 4, 1, 1'b0, 28'd134184963, 28'd134184962);
`else
    beat_k(1'b1, 5, 3, 1'b1, 8, 2);
    beat_k(1'b1, 4, 1, 1'b0, 5, 3);
`endif
    idle(LAT);

    // Reset in the middle of a stream
    for (int i = 0; i < 10; i++) begin
      rm = 1'(($urandom_range(0, 1)));
      rx = W'($urandom_range(QV - 1, 0));
      ry = W'($urandom_range(QV - 1, 0));
      step(1'b1, rm, rx, ry, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, (i == 4));
    end
    idle(LAT + 2);
    beat_k(1'b0, 0, 7, 1'b0, 7, QV - 7);

    // Edge operands with non-trivial twiddles
    tw_wr(0, QV - 1);
    tw_wr(1, 28'd12345678);
    beat(1'b0, QV - 1, QV - 1, 1'b1);
    beat(1'b1, QV - 1, QV - 1, 1'b0);
    beat(1'b1, 0, QV - 1, 1'b0);
    beat(1'b0, 0, 0, 1'b0);
    beat(1'b1, 1, 2, 1'b0);

    // Random mixed stream with bubbles, restarts and table writes
    for (int i = 0; i < 60; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rm  = 1'(($urandom_range(0, 1)));
      rrs = ($urandom_range(0, 9) == 0);
      rwe = ($urandom_range(0, 4) == 0);
      rx  = W'($urandom_range(QV - 1, 0));
      ry  = W'($urandom_range(QV - 1, 0));
      rd  = W'($urandom_range(QV - 1, 0));
      ra  = AW'($urandom_range(NT - 1, 0));
      step(rv, rm, rx, ry, rrs, rwe, ra, rd, 1'b0, '0, '0, 1'b0);
    end
    idle(LAT + 3);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
